// File: rtl/serial_pkg.sv
// Shared state encoding and default parameters for the serial pattern detector slice.
package serial_pkg;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_ARMED   = 2'd2;

  localparam int         DEF_PATTERN_WIDTH = 4;
  localparam logic [3:0] DEF_PATTERN       = 4'b1011;
  localparam int         DEF_CNT_WIDTH     = 8;

endpackage

// File: rtl/sipo_window.sv
// Serial-in parallel-out window of W falling-edge cells; bit 0 is the newest bit.
// Shifts one bit per enabled edge, clear beats shift; window_next exposes the pre-load value.
module sipo_window #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         shift_en,
  input  logic         din,
  output logic [W-1:0] window,
  output logic [W-1:0] window_next
);

  assign window_next = {window[W-2:0], din};

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      window <= '0;
    end else if (clear) begin
      window <= '0;
    end else if (shift_en) begin
      window <= window_next;
    end
  end

endmodule

// File: rtl/serial_pattern_detector.sv
// Detects PATTERN in a serial stream, pulsing match on the edge that shifts in the completing bit.
// Counts matches with saturation; din_valid=0 holds all state, clear resets window, fill and count.
module serial_pattern_detector
  import serial_pkg::*;
#(
  parameter int                       PATTERN_WIDTH = DEF_PATTERN_WIDTH,
  parameter logic [PATTERN_WIDTH-1:0] PATTERN       = PATTERN_WIDTH'(DEF_PATTERN),
  parameter bit                       OVERLAP       = 1'b1,
  parameter int                       CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     din,
  input  logic                     din_valid,
  input  logic                     clear,
  output logic                     match,
  output logic                     armed,
  output logic [PATTERN_WIDTH-1:0] window,
  output logic [CNT_WIDTH-1:0]     match_count
);

  localparam int                FILL_W    = $clog2(PATTERN_WIDTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_WIDTH);

  logic [PATTERN_WIDTH-1:0] window_next;
  logic [FILL_W-1:0]        fill;
  logic [FILL_W-1:0]        fill_inc;
  logic [FILL_W-1:0]        fill_next;
  logic [1:0]               state;
  logic [1:0]               state_next;
  logic                     shift;
  logic                     hit;

  sipo_window #(
    .W (PATTERN_WIDTH)
  ) u_window (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .shift_en    (din_valid),
    .din         (din),
    .window      (window),
    .window_next (window_next)
  );

  assign shift    = din_valid && !clear;
  assign fill_inc = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;

  // Fill gating keeps an all-zero pattern from matching the reset contents.
  assign hit = shift && (fill_inc == FILL_FULL) && (window_next == PATTERN);

  always_comb begin
    fill_next  = fill;
    state_next = state;
    if (shift) begin
      fill_next = fill_inc;
      case (state)
        ST_EMPTY,
        ST_FILLING: state_next = (fill_inc == FILL_FULL) ? ST_ARMED : ST_FILLING;
        ST_ARMED:   state_next = ST_ARMED;
        default:    state_next = ST_EMPTY;
      endcase
      if (hit && !OVERLAP) begin
        fill_next  = '0;
        state_next = ST_EMPTY;
      end
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      fill        <= '0;
      state       <= ST_EMPTY;
      match       <= 1'b0;
      match_count <= '0;
    end else if (clear) begin
      fill        <= '0;
      state       <= ST_EMPTY;
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      fill  <= fill_next;
      state <= state_next;
      match <= hit;
      if (hit && (match_count != '1)) begin
        match_count <= match_count + 1'b1;
      end
    end
  end

  assign armed = (state == ST_ARMED);

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Directed bench: four detector variants share one stimulus stream, each checked against hand-derived values.
module tb_serial_pattern_detector;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic clear = 1'b0;

  logic       ovl_match,  ovl_armed;
  logic [3:0] ovl_window;
  logic [7:0] ovl_count;
  logic       nov_match,  nov_armed;
  logic [3:0] nov_window;
  logic [7:0] nov_count;
  logic       sat_match,  sat_armed;
  logic [3:0] sat_window;
  logic [1:0] sat_count;
  logic       zer_match,  zer_armed;
  logic [3:0] zer_window;
  logic [7:0] zer_count;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  serial_pattern_detector u_ovl (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear(clear),
    .match(ovl_match), .armed(ovl_armed), .window(ovl_window), .match_count(ovl_count)
  );

  serial_pattern_detector #(.OVERLAP(1'b0)) u_nov (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear(clear),
    .match(nov_match), .armed(nov_armed), .window(nov_window), .match_count(nov_count)
  );

  serial_pattern_detector #(.CNT_WIDTH(2)) u_sat (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear(clear),
    .match(sat_match), .armed(sat_armed), .window(sat_window), .match_count(sat_count)
  );

  serial_pattern_detector #(.PATTERN(4'b0000)) u_zer (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear(clear),
    .match(zer_match), .armed(zer_armed), .window(zer_window), .match_count(zer_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive between edges, let the falling edge act, then sample just after it.
  task automatic step(input logic d, input logic v, input logic c);
    @(posedge clk);
    din       = d;
    din_valid = v;
    clear     = c;
    @(negedge clk);
    #1;
  endtask

  task automatic chk_ovl(input string tag, input logic m, input logic a, input logic [7:0] n);
    chk({tag, ".ovl_match"}, 32'(ovl_match), 32'(m));
    chk({tag, ".ovl_armed"}, 32'(ovl_armed), 32'(a));
    chk({tag, ".ovl_count"}, 32'(ovl_count), 32'(n));
  endtask

  task automatic chk_nov(input string tag, input logic m, input logic a, input logic [7:0] n);
    chk({tag, ".nov_match"}, 32'(nov_match), 32'(m));
    chk({tag, ".nov_armed"}, 32'(nov_armed), 32'(a));
    chk({tag, ".nov_count"}, 32'(nov_count), 32'(n));
  endtask

  initial begin
    // Reset state, observed while reset is still asserted
    #2;
    chk_ovl("reset", 1'b0, 1'b0, 8'd0);
    chk("reset.window", 32'(ovl_window), 32'h0);
    #1 reset = 1'b0;

    // Stream 1,0,1,1,0,1,1,0: overlapping and non-overlapping variants side by side
    step(1, 1, 0); chk_ovl("t1.b1", 0, 0, 0); chk_nov("t2.b1", 0, 0, 0);
    step(0, 1, 0); chk_ovl("t1.b2", 0, 0, 0);
    step(1, 1, 0); chk_ovl("t1.b3", 0, 0, 0); chk_nov("t2.b3", 0, 0, 0);
    step(1, 1, 0); chk_ovl("t1.b4", 1, 1, 1); chk_nov("t2.b4", 1, 0, 1);
    chk("t1.b4.window", 32'(ovl_window), 32'hB);
    chk("t2.b4.window", 32'(nov_window), 32'hB);
    step(0, 1, 0); chk_ovl("t1.b5", 0, 1, 1); chk_nov("t2.b5", 0, 0, 1);
    step(1, 1, 0); chk_ovl("t1.b6", 0, 1, 1);
    step(1, 1, 0); chk_ovl("t1.b7", 1, 1, 2); chk_nov("t2.b7", 0, 0, 1);
    step(0, 1, 0); chk_ovl("t1.b8", 0, 1, 2); chk_nov("t2.b8", 0, 1, 1);
    chk("t1.sat_count", 32'(sat_count), 32'd2);

    // Clear, then 1,0, three invalid cycles, then 1,1
    step(0, 1, 1); chk_ovl("t3.clear", 0, 0, 0);
    chk("t3.clear.window", 32'(ovl_window), 32'h0);
    step(1, 1, 0);
    step(0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      chk($sformatf("t3.gap%0d.window", i), 32'(ovl_window), 32'h2);
      chk($sformatf("t3.gap%0d.match", i), 32'(ovl_match), 32'd0);
    end
    step(1, 1, 0); chk_ovl("t3.b3", 0, 0, 0);
    step(1, 1, 0); chk_ovl("t3.b4", 1, 1, 1);
    step(0, 0, 0); chk("t3.pulse_end", 32'(ovl_match), 32'd0);

    // Five back-to-back 1011 groups against a 2-bit saturating counter
    step(0, 1, 1); chk("t4.clear.sat", 32'(sat_count), 32'd0);
    for (int g = 0; g < 5; g++) begin
      step(1, 1, 0);
      step(0, 1, 0);
      step(1, 1, 0);
      chk($sformatf("t4.g%0d.pre", g), 32'(sat_match), 32'd0);
      step(1, 1, 0);
      chk($sformatf("t4.g%0d.match", g), 32'(sat_match), 32'd1);
      chk($sformatf("t4.g%0d.count", g), 32'(sat_count), (g < 3) ? 32'(g + 1) : 32'd3);
    end
    chk("t4.ovl_count", 32'(ovl_count), 32'd5);

    // Reset between edges after a partial 1,0,1
    step(1, 1, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    chk_ovl("t5.pre", 0, 1, 5);
    reset     = 1'b1;
    din_valid = 1'b0;
    #1;
    chk_ovl("t5.async", 0, 0, 0);
    chk("t5.async.window", 32'(ovl_window), 32'h0);
    #1 reset = 1'b0;
    step(1, 1, 0); chk_ovl("t5.b1", 0, 0, 0);
    chk("t5.b1.window", 32'(ovl_window), 32'h1);
    step(0, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0); chk_ovl("t5.full", 1, 1, 1);

    // All-zero pattern: clear, three zeros, clear colliding with the fourth, then four zeros
    step(0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0);
      chk($sformatf("t6.z%0d.match", i), 32'(zer_match), 32'd0);
    end
    step(0, 1, 1);
    chk("t6.collide.match", 32'(zer_match), 32'd0);
    chk("t6.collide.count", 32'(zer_count), 32'd0);
    chk("t6.collide.armed", 32'(zer_armed), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0);
      chk($sformatf("t6.r%0d.match", i), 32'(zer_match), 32'd0);
    end
    step(0, 1, 0);
    chk("t6.hit.match", 32'(zer_match), 32'd1);
    chk("t6.hit.count", 32'(zer_count), 32'd1);
    chk("t6.hit.armed", 32'(zer_armed), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
